data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between a core and the data memory responder
interface data_mem_responder_if;
  logic        read_enable_data_mem;
  logic        write_enable_data_mem;
  logic [31:0] address_for_data_mem;
  logic [31:0] data_to_mem;
  logic [2:0]  mem_size;
  logic [31:0] data_from_mem;
  logic        mem_ready;
  logic        mem_error;
  logic        busy;

  modport slave (
    input  read_enable_data_mem, write_enable_data_mem, address_for_data_mem,
           data_to_mem, mem_size,
    output data_from_mem, mem_ready, mem_error, busy
  );

  modport master (
    output read_enable_data_mem, write_enable_data_mem, address_for_data_mem,
           data_to_mem, mem_size,
    input  data_from_mem, mem_ready, mem_error, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory with byte/half/word lanes and fixed wait states
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,  // power of two, at least 2
  parameter int WAIT_CYCLES = 1     // 0..15
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    size_q;
  logic          we_q, both_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          in_idle, req, accept, acc_fire;
  logic [AW+1:0] acc_addr;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_size;
  logic          acc_we, acc_both, acc_err;
  logic          is_byte, is_half, is_word;
  logic [31:0]   wmask, wsh, mem_word;
  logic          unused_addr_bits;

  assign in_idle = (state_q == S_IDLE);
  assign req     = bus.read_enable_data_mem | bus.write_enable_data_mem;
  assign accept  = in_idle & req;

  // With zero wait states the access happens on the accept edge itself, so
  // the operands come straight from the bus instead of the latched copies.
  assign acc_addr  = in_idle ? bus.address_for_data_mem[AW+1:0] : addr_q;
  assign acc_wdata = in_idle ? bus.data_to_mem : wdata_q;
  assign acc_size  = in_idle ? bus.mem_size : size_q;
  assign acc_we    = in_idle ? bus.write_enable_data_mem : we_q;
  assign acc_both  = in_idle ? (bus.read_enable_data_mem & bus.write_enable_data_mem) : both_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign mem_word  = mem[acc_idx];

  // Upper address bits only alias onto the wrapped word index.
  assign unused_addr_bits = ^bus.address_for_data_mem[31:AW+2];

  // Size decode, fault detection and store lane placement
  always_comb begin
    is_byte = (acc_size == 3'b000) || (acc_size == 3'b100);
    is_half = (acc_size == 3'b001) || (acc_size == 3'b101);
    is_word = (acc_size == 3'b010);
    acc_err = acc_both || !(is_byte || is_half || is_word) ||
              (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
    wmask = 32'h0;
    wsh   = 32'h0;
    if (is_byte) begin
      wmask = 32'h0000_00ff << {acc_addr[1:0], 3'b000};
      wsh   = {24'h0, acc_wdata[7:0]} << {acc_addr[1:0], 3'b000};
    end else if (is_half) begin
      wmask = 32'h0000_ffff << {acc_addr[1], 4'b0000};
      wsh   = {16'h0, acc_wdata[15:0]} << {acc_addr[1], 4'b0000};
    end else if (is_word) begin
      wmask = 32'hffff_ffff;
      wsh   = acc_wdata;
    end
  end

  // Next-state logic; the array access fires on every entry into RESP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            acc_fire = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          acc_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= 3'b000;
      we_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.address_for_data_mem[AW+1:0];
        wdata_q <= bus.data_to_mem;
        size_q  <= bus.mem_size;
        we_q    <= bus.write_enable_data_mem;
        both_q  <= bus.read_enable_data_mem & bus.write_enable_data_mem;
      end
      if (acc_fire) begin
        rdata_q <= (acc_we || acc_err) ? 32'h0 : (mem_word >> {acc_addr[1:0], 3'b000});
        err_q   <= acc_err;
      end
    end
  end

  // Storage array: never cleared, written only by a fault-free store entering RESP
  always_ff @(posedge clk) begin
    if (!rst && acc_fire && acc_we && !acc_err) begin
      mem[acc_idx] <= (mem_word & ~wmask) | (wsh & wmask);
    end
  end

  assign bus.mem_ready     = (state_q == S_RESP);
  assign bus.mem_error     = err_q & (state_q == S_RESP);
  assign bus.data_from_mem = rdata_q;
  assign bus.busy          = !in_idle;

endmodule
